// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer states,
// frame data width and the default baud divisor.
package uart_pkg;

   localparam int unsigned DATA_BITS            = 8;
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO with a combinational head read; storage is not
// reset, only the pointers and occupancy count.
module byte_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  push_ok;
   logic                  pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally at 2^DEPTH_LOG2.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: bytes pushed by the CPU are queued in a
// byte_fifo and serialized LSB first by a registered-output FSM.
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned DEPTH_LOG2   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push_enable,
   input  logic [7:0] push_data,
   output logic       tx,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       overflow
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   tx_state_t              state;
   tx_state_t              state_next;
   logic [CNT_W-1:0]       baud;
   logic [CNT_W-1:0]       baud_next;
   logic [IDX_W-1:0]       bit_idx;
   logic [IDX_W-1:0]       bit_next;
   logic [IDX_W-1:0]       bit_inc;
   logic [DATA_BITS-1:0]   shift;
   logic [DATA_BITS-1:0]   shift_next;
   logic                   tx_next;
   logic                   bit_end;
   logic                   pop_c;
   logic [7:0]             head;

   byte_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_enable),
      .pop   (pop_c),
      .wdata (push_data),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign busy    = (state != IDLE);
   assign bit_end = (baud == CNT_W'(CLKS_PER_BIT - 1));
   assign bit_inc = bit_idx + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         overflow <= 1'b0;
      end else begin
         state    <= state_next;
         baud     <= baud_next;
         bit_idx  <= bit_next;
         shift    <= shift_next;
         tx       <= tx_next;
         overflow <= overflow | (push_enable & full);
      end
   end

   // tx_next is the line level for the state being entered, so tx stays a pure flop.
   always_comb begin
      state_next = state;
      baud_next  = baud;
      bit_next   = bit_idx;
      shift_next = shift;
      tx_next    = tx;
      pop_c      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop_c      = 1'b1;
               shift_next = head;
               state_next = START;
               baud_next  = '0;
               bit_next   = '0;
               tx_next    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_next = DATA;
               baud_next  = '0;
               tx_next    = shift[0];
            end else begin
               baud_next = baud + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_next = '0;
               if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_next = bit_inc;
                  tx_next  = shift[bit_inc];
               end
            end else begin
               baud_next = baud + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               state_next = IDLE;
               baud_next  = '0;
               tx_next    = 1'b1;
            end else begin
               baud_next = baud + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: directed scenarios plus random traffic, checked
// every cycle against a frame-schedule model of the transmitter.
module tb_uart_tx_buffer;

   localparam int CPB    = 4;
   localparam int DL2    = 2;
   localparam int DEPTH  = 4;
   localparam int FRAME  = 10 * CPB;
   localparam int PERIOD = FRAME + 1;

   logic       clk;
   logic       reset;
   logic       push_enable;
   logic [7:0] push_data;
   logic       tx;
   logic       full;
   logic       empty;
   logic       busy;
   logic       overflow;

   uart_tx_buffer #(
      .CLKS_PER_BIT (CPB),
      .DEPTH_LOG2   (DL2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .push_enable (push_enable),
      .push_data   (push_data),
      .tx          (tx),
      .full        (full),
      .empty       (empty),
      .busy        (busy),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each accepted byte: push cycle, first start-bit cycle, payload.
   typedef struct {
      int         p;
      int         s;
      logic [7:0] d;
   } frame_t;

   frame_t fq[$];
   int     cyc;
   int     last_start;
   int     checks;
   int     passes;
   bit     ovf_m;
   bit     chk_en;

   // Bytes sitting in the FIFO during cycle c (popped the cycle before start).
   function automatic int occ(int c);
      int n = 0;
      foreach (fq[i]) if (fq[i].p < c && fq[i].s > c) n++;
      return n;
   endfunction

   function automatic logic exp_tx(int c);
      foreach (fq[i]) begin
         if (c >= fq[i].s && c < fq[i].s + FRAME) begin
            int o;
            o = (c - fq[i].s) / CPB;
            if (o == 0) return 1'b0;
            if (o == 9) return 1'b1;
            return fq[i].d[o-1];
         end
      end
      return 1'b1;
   endfunction

   function automatic logic exp_busy(int c);
      foreach (fq[i]) if (c >= fq[i].s && c < fq[i].s + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
   endtask

   // One clock cycle: check outputs for this cycle, then drive inputs for it.
   task automatic step(input logic pe, input logic [7:0] pd, input logic rst);
      int o;
      @(negedge clk);
      if (chk_en) begin
         o = occ(cyc);
         chk("tx",       tx,       exp_tx(cyc));
         chk("busy",     busy,     exp_busy(cyc));
         chk("empty",    empty,    o == 0);
         chk("full",     full,     o == DEPTH);
         chk("overflow", overflow, ovf_m);
      end
      push_enable = pe;
      push_data   = pd;
      reset       = rst;
      if (rst) begin
         fq.delete();
         last_start = -1000;
         ovf_m      = 1'b0;
      end else if (pe) begin
         if (occ(cyc) == DEPTH) begin
            ovf_m = 1'b1;
         end else begin
            frame_t f;
            f.p = cyc;
            f.s = (cyc + 2 > last_start + PERIOD) ? cyc + 2 : last_start + PERIOD;
            f.d = pd;
            fq.push_back(f);
            last_start = f.s;
         end
      end
      cyc++;
      while (fq.size() > 0 && fq[0].s + FRAME < cyc) void'(fq.pop_front());
   endtask

   task automatic drain();
      int n;
      n = last_start + PERIOD - cyc + 3;
      if (n < 3) n = 3;
      repeat (n) step(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      int s0;
      logic [7:0] b;
      cyc         = 0;
      checks      = 0;
      passes      = 0;
      ovf_m       = 1'b0;
      last_start  = -1000;
      chk_en      = 1'b0;
      reset       = 1'b1;
      push_enable = 1'b0;
      push_data   = 8'h00;

      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk_en = 1'b1;
      step(1'b0, 8'h00, 1'b0);

      // Single byte framing and latency.
      step(1'b1, 8'hA5, 1'b0);
      drain();

      // Back-to-back bytes.
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'hFF, 1'b0);
      drain();

      // Six consecutive pushes overrun a four-entry FIFO.
      for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
      drain();
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Keep pushing through a whole frame so a push lands in the pop cycle while full.
      for (int i = 0; i < PERIOD + 8; i++) step(1'b1, 8'($urandom), 1'b0);
      drain();
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Reset during data bit 3 of 0x3C, then a clean 0x81.
      step(1'b1, 8'h3C, 1'b0);
      s0 = last_start;
      while (cyc < s0 + 17) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h81, 1'b0);
      drain();

      // Ten sequential bytes wrap the pointers more than twice.
      for (int i = 0; i < 10; i++) begin
         b = 8'(8'h10 + i);
         for (int w = 0; w < 4 * PERIOD && occ(cyc) == DEPTH; w++) step(1'b0, 8'h00, 1'b0);
         step(1'b1, b, 1'b0);
      end
      drain();

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) step(1'b0, 8'h00, 1'b1);
         else step(1'($urandom_range(0, 9) < 2), 8'($urandom), 1'b0);
      end
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, log2 of FIFO depth (16 entries).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port push_enable  input  1  byte-push strobe, driven by the CPU's tx_send_enable.
REQ-006 SHALL have port push_data  input  8  byte to send, driven by the CPU's tx_send_data.
REQ-007 SHALL have port tx  output  1  serial line, idle high.
REQ-008 SHALL have port full  output  1  FIFO holds 2^DEPTH_LOG2 bytes.
REQ-009 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-010 SHALL have port busy  output  1  serializer not IDLE.
REQ-011 SHALL have port overflow  output  1  sticky: a push was dropped.

Function
REQ-012 SHALL accept a push when push_enable=1 and full=0; the byte SHALL be stored at the write pointer, and count SHALL increment at the next edge.
REQ-013 SHALL drop a push when full=0 is false (full=1), even if a pop occurs in the same cycle; overflow SHALL be set at the next edge and held until reset.
REQ-014 SHALL transmit bytes in push order; pointers wrap modulo 2^DEPTH_LOG2.
REQ-015 SHALL use serializer states IDLE, START, DATA, STOP.
REQ-016 IDLE with empty=0 SHALL pop the head byte into the shift register and enter START at the next edge; a byte pushed into an empty FIFO SHALL NOT be popped in the same cycle as its push.
REQ-017 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-018 DATA SHALL drive 8 bits, LSB first, each for CLKS_PER_BIT cycles, using a 3-bit index; after bit 7 it SHALL enter STOP.
REQ-019 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then enter IDLE.
REQ-020 Back-to-back bytes SHALL have exactly one IDLE cycle between STOP end and the next START; frame period = 10*CLKS_PER_BIT+1 cycles.
REQ-021 The baud counter SHALL count 0..CLKS_PER_BIT-1, reload to 0 on each bit boundary and on each state change, and be $clog2(CLKS_PER_BIT) bits wide.
REQ-022 tx SHALL be registered, with no combinational path from any input.
REQ-023 Simultaneous push (not full) and pop SHALL leave count unchanged and store and read the correct entries.
REQ-024 full, empty and busy SHALL reflect the registered state in the current cycle; count SHALL be DEPTH_LOG2+1 bits wide.

Reset
REQ-025 reset=1 SHALL force the following at the next edge, aborting any frame in progress:
- state=IDLE
- tx=1
- pointers and count = 0
- empty=1, full=0, busy=0, overflow=0
REQ-026 FIFO storage SHALL NOT be reset.

Structure
REQ-027 The shared package uart_pkg SHALL hold:
- the state enum (IDLE, START, DATA, STOP)
- DATA_BITS=8
- default CLKS_PER_BIT
REQ-028 The FIFO SHALL be a sub-module named byte_fifo (parameter DEPTH_LOG2; ports push, pop, wdata, rdata, full, empty). rdata SHALL be combinational from the head entry. The serializer FSM SHALL live in uart_tx_buffer.

Verification (CLKS_PER_BIT=4, DEPTH_LOG2=2)
REQ-029 Single byte: push 0xA5 at cycle 0 -> tx falls at cycle 2; sampling mid-bit gives 0,1,0,1,0,0,1,0,1,1; IDLE by cycle 42; busy high cycles 2..41.
REQ-030 Back-to-back: push 0x00 then 0xFF on consecutive cycles -> second start bit begins exactly 41 cycles after the first; overflow=0.
REQ-031 Overflow: push 6 bytes in 6 consecutive cycles -> the 5th or 6th push is dropped exactly when full=1; overflow=1 sticky; only the accepted bytes appear on tx, in order.
REQ-032 Simultaneous push/pop at full: FIFO full with serializer IDLE, then push in the pop cycle -> push dropped, overflow=1, count drops 4->3.
REQ-033 Reset mid-frame: assert reset during DATA bit 3 of 0x3C -> next cycle tx=1, busy=0, empty=1; a subsequent push of 0x81 transmits cleanly.
REQ-034 Pointer wrap: push and drain 10 sequential bytes 0x10..0x19 -> all received in order, and empty=1 at the end.
